// File: rtl/pwm_pkg.sv
// Shared mode encoding and default sizes for the PWM timebase slice.
// Pure declarations; no logic, no latency, no flow control.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_DEF   = 16;
    localparam int unsigned PWM_PRESC_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UPDOWN = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the timebase: step fires once every 2**prescale enabled clocks.
// step is combinational from the registered divider count; no backpressure, clr wins over en.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] prescale,
    output logic               step
);

    localparam int unsigned CNT_W = (1 << PRESC_W) - 1;

    logic [CNT_W-1:0] psc_cnt_q;
    logic [CNT_W-1:0] psc_cnt_d;
    logic [CNT_W:0]   ratio;
    logic [CNT_W-1:0] limit;

    assign ratio = (CNT_W+1)'(1) << prescale;
    assign limit = ratio[CNT_W-1:0] - CNT_W'(1);

    // >= rather than == so that shrinking prescale mid-count steps at once instead of wrapping.
    assign step = en && !clr && (psc_cnt_q >= limit);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr) begin
            psc_cnt_d = '0;
        end else if (en) begin
            psc_cnt_d = step ? '0 : psc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: up, down and center-aligned counter with shadowed period and wrap pulses.
// All outputs registered, pulses coincide with the new count; no backpressure.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH      = PWM_WIDTH_DEF,
    parameter int unsigned      PRESC_W    = PWM_PRESC_W_DEF,
    parameter logic [WIDTH-1:0] PERIOD_RST = WIDTH'(16'hFFFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               count_reset,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [WIDTH-1:0]   period,
    output logic [WIDTH-1:0]   count_val,
    output logic               dir,
    output logic               tick,
    output logic               ovf,
    output logic               unf,
    output logic               upd
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode_sel;
    logic             step;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             upd_q, upd_d;

    assign mode_sel = mode_e'(mode);

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (count_reset),
        .prescale (prescale),
        .step     (step)
    );

    always_comb begin
        count_d      = count_q;
        dir_d        = dir_q;
        period_act_d = period_act_q;
        tick_d       = 1'b0;
        ovf_d        = 1'b0;
        unf_d        = 1'b0;
        upd_d        = 1'b0;

        if (count_reset) begin
            count_d      = '0;
            dir_d        = (mode_sel != MODE_DOWN);
            period_act_d = period;
        end else if (!en) begin
            period_act_d = period;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_sel)
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == '0) begin
                        count_d      = period;
                        period_act_d = period;
                        unf_d        = 1'b1;
                        upd_d        = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                MODE_UPDOWN: begin
                    // A zero period collapses the triangle: sit at 0, treat every step as a valley.
                    if (period_act_q == '0) begin
                        count_d      = '0;
                        dir_d        = 1'b1;
                        unf_d        = 1'b1;
                        upd_d        = 1'b1;
                        period_act_d = period;
                    end else if (dir_q) begin
                        if (count_q >= period_act_q) begin
                            dir_d   = 1'b0;
                            count_d = period_act_q - ONE;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else if (count_q == '0) begin
                        dir_d        = 1'b1;
                        count_d      = ONE;
                        unf_d        = 1'b1;
                        upd_d        = 1'b1;
                        period_act_d = period;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                default: begin
                    dir_d = 1'b1;
                    if (count_q >= period_act_q) begin
                        count_d      = '0;
                        ovf_d        = 1'b1;
                        upd_d        = 1'b1;
                        period_act_d = period;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            dir_q        <= 1'b1;
            period_act_q <= PERIOD_RST;
            tick_q       <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            dir_q        <= dir_d;
            period_act_q <= period_act_d;
            tick_q       <= tick_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            upd_q        <= upd_d;
        end
    end

    assign count_val = count_q;
    assign dir       = dir_q;
    assign tick      = tick_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign upd       = upd_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a rule-level model of the counter.
module tb_pwm_timebase;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        count_reset;
    logic [1:0]  mode;
    logic [3:0]  prescale;
    logic [15:0] period;
    logic [15:0] count_val;
    logic        dir, tick, ovf, unf, upd;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model state: counts are plain integers, the divider is "enabled clocks since last step".
    int m_cnt = 0;
    int m_pa  = 16'hFFFF;
    int m_psc = 0;
    bit m_dir = 1'b1;
    bit m_tick = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_upd = 1'b0;

    int seq_ud [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

    pwm_timebase dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_reset (count_reset),
        .mode        (mode),
        .prescale    (prescale),
        .period      (period),
        .count_val   (count_val),
        .dir         (dir),
        .tick        (tick),
        .ovf         (ovf),
        .unf         (unf),
        .upd         (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pa = 16'hFFFF; m_psc = 0; m_dir = 1'b1;
        m_tick = 0; m_ovf = 0; m_unf = 0; m_upd = 0;
    endtask

    task automatic model_edge();
        int div;
        div = 1 << prescale;
        m_tick = 0; m_ovf = 0; m_unf = 0; m_upd = 0;
        if (count_reset) begin
            m_cnt = 0; m_psc = 0; m_pa = period;
            m_dir = (mode != 2'b01);
        end else if (!en) begin
            m_pa = period;
        end else if (m_psc + 1 < div) begin
            m_psc++;
        end else begin
            m_psc  = 0;
            m_tick = 1;
            if (mode == 2'b01) begin
                m_dir = 0;
                if (m_cnt == 0) begin
                    m_cnt = period; m_pa = period; m_unf = 1; m_upd = 1;
                end else m_cnt--;
            end else if (mode == 2'b10) begin
                if (m_pa == 0) begin
                    m_cnt = 0; m_dir = 1; m_unf = 1; m_upd = 1; m_pa = period;
                end else if (m_dir && m_cnt >= m_pa) begin
                    m_dir = 0; m_cnt = m_pa - 1; m_ovf = 1;
                end else if (m_dir) begin
                    m_cnt++;
                end else if (m_cnt == 0) begin
                    m_dir = 1; m_cnt = 1; m_unf = 1; m_upd = 1; m_pa = period;
                end else m_cnt--;
            end else begin
                m_dir = 1;
                if (m_cnt >= m_pa) begin
                    m_cnt = 0; m_ovf = 1; m_upd = 1; m_pa = period;
                end else m_cnt++;
            end
        end
        m_cnt = m_cnt & 16'hFFFF;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("count", 32'(count_val), 32'(m_cnt));
                check("flags", {27'd0, dir, tick, ovf, unf, upd},
                       {27'd0, m_dir, m_tick, m_ovf, m_unf, m_upd});
            end
        end
    end

    initial begin
        rst_n = 1'b1; en = 1'b0; count_reset = 1'b0; mode = 2'b00; prescale = 4'd0; period = 16'd8;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count_val), 32'd0);
        check("rst_flags", {27'd0, dir, tick, ovf, unf, upd}, 32'b10000);
        check("rst_period", 32'(dut.period_act_q), 32'hFFFF);
        chk_on = 1'b1;
        clks(2);
        rst_n = 1'b1; en = 1'b1;
        clks(3);
        check("run3", 32'(count_val), 32'd3);
        count_reset = 1'b1;
        clks(1);
        check("clr", 32'(count_val), 32'd0);
        count_reset = 1'b0; en = 1'b0;
        clks(5);
        check("hold_en0", 32'(count_val), 32'd0);

        en = 1'b1;
        clks(4);
        check("up_p0", 32'(count_val), 32'd4);
        prescale = 4'd1;
        clks(4);
        check("up_p1", 32'(count_val), 32'd6);
        prescale = 4'd2;
        clks(8);
        check("up_p2", 32'(count_val), 32'd8);
        clks(4);
        check("up_wrap", {15'd0, count_val, ovf}, {15'd0, 16'd0, 1'b1});
        check("up_wrap_upd", 32'(upd), 32'd1);

        mode = 2'b01;
        clks(4);
        check("dn_load", {15'd0, count_val, unf}, {15'd0, 16'd8, 1'b1});
        check("dn_dir", 32'(dir), 32'd0);
        clks(4);
        check("dn_7", 32'(count_val), 32'd7);
        clks(28);
        check("dn_0", 32'(count_val), 32'd0);
        clks(4);
        check("dn_reload", 32'(count_val), 32'd8);

        period = 16'd4; mode = 2'b10; prescale = 4'd0; count_reset = 1'b1;
        clks(1);
        count_reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            clks(1);
            check("ud_seq", 32'(count_val), 32'(seq_ud[i]));
            check("ud_pulse", {30'd0, ovf, unf}, {30'd0, (i == 4), (i == 8)});
        end

        mode = 2'b00; period = 16'd8; count_reset = 1'b1;
        clks(1);
        count_reset = 1'b0;
        clks(5);
        check("sh_5", 32'(count_val), 32'd5);
        period = 16'd3;
        clks(3);
        check("sh_8", 32'(count_val), 32'd8);
        clks(1);
        check("sh_wrap", {15'd0, count_val, upd}, {15'd0, 16'd0, 1'b1});
        clks(3);
        check("sh_3", {15'd0, count_val, ovf}, {15'd0, 16'd3, 1'b0});
        clks(1);
        check("sh_wrap2", {15'd0, count_val, ovf}, {15'd0, 16'd0, 1'b1});

        period = 16'd0; count_reset = 1'b1;
        clks(1);
        count_reset = 1'b0;
        repeat (3) begin
            clks(1);
            check("p0_up", {15'd0, count_val, ovf}, {15'd0, 16'd0, 1'b1});
        end

        period = 16'd8; prescale = 4'd3; count_reset = 1'b1;
        clks(1);
        count_reset = 1'b0;
        clks(5);
        check("psc_wait", 32'(count_val), 32'd0);
        prescale = 4'd0;
        clks(1);
        check("psc_shrink", {15'd0, count_val, tick}, {15'd0, 16'd1, 1'b1});

        clks(3);
        check("pre_arst", 32'(count_val), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count_val), 32'd0);
        check("arst_period", 32'(dut.period_act_q), 32'hFFFF);
        check("arst_tick", 32'(tick), 32'd0);
        clks(1);
        rst_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            en          = ($urandom_range(0, 9) != 0);
            count_reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                period = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            clks(1);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
Parametrised timebase counter for the PWM generator. It is the successor of the single-mode up/down counter, and adds:
- configurable width
- a prescaler with a parametrised exponent range
- a center-aligned (up-down) mode
- shadow-buffered period, applied only at update events
- wrap event pulses
Its outputs feed the per-channel compare logic and the interrupt/status register block.

Parameters:
WIDTH, 16, counter and period width in bits.
PRESC_W, 4, width of prescale exponent; divide ratio = 2**prescale, prescaler counter is (2**PRESC_W - 1) bits.
PERIOD_RST, 16'hFFFF (truncated to WIDTH), reset value of the active period register.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  count enable.
count_reset  input  1  synchronous counter clear; priority over en.
mode  input  2  00 up, 01 down, 10 up-down (center-aligned), 11 reserved (behaves as up).
prescale  input  PRESC_W  divide exponent; 0 = step every clk.
period  input  WIDTH  shadow period, transferred per update rules below.
count_val  output  WIDTH  current count.
dir  output  1  1 = counting up, 0 = counting down.
tick  output  1  one-clk pulse on every count step.
ovf  output  1  one-clk pulse: up-wrap (up mode) or peak turn (up-down).
unf  output  1  one-clk pulse: down-wrap (down mode) or valley turn (up-down).
upd  output  1  one-clk pulse when period_act is loaded from period during counting.

Behaviour:
- Reset (rst_n=0, async): count_val=0, dir=1, psc_cnt=0, period_act=PERIOD_RST, tick/ovf/unf/upd=0.
- All outputs are registered. Pulses assert in the same cycle count_val takes its new value.
- Priority per clk edge: count_reset > en=0 > counting.
- count_reset=1:
  - count_val=0, psc_cnt=0.
  - dir=1 (dir=0 in down mode).
  - period_act=period.
  - No pulses.
  - count_val reads 0 on the edge after count_reset is sampled.
- en=0: count_val, dir and psc_cnt hold; period_act tracks period every clk; no pulses.
- Prescaler:
  - Step condition: en=1 and psc_cnt >= (2**prescale)-1. On a step, psc_cnt←0; otherwise psc_cnt+1.
  - The >= comparison means a reduced prescale takes effect without a stall.
  - prescale=0 gives a step every enabled clk.
  - tick=1 on each step.
- Up mode, on step:
  - If count_val >= period_act: count_val←0, ovf=1, upd=1, period_act←period.
  - Else count_val+1.
- Down mode, on step:
  - If count_val==0: count_val←period (the new value), period_act←period, unf=1, upd=1.
  - Else count_val-1.
  - dir is held at 0.
- Up-down mode, on step:
  - dir=1 and count_val >= period_act: dir←0, count_val←period_act-1, ovf=1 (peak; no period update).
  - dir=1, otherwise: count_val+1.
  - dir=0 and count_val==0: dir←1, count_val←1, unf=1, upd=1, period_act←period (valley update).
  - dir=0, otherwise: count_val-1.
  - Period of a full triangle = 2*period_act steps.
- period_act==0:
  - count_val is held at 0.
  - Up mode: ovf+upd pulse every step.
  - Down and up-down modes: unf+upd pulse every step; dir stays 1 in up-down.
- Mode change while counting: takes effect on the next step.
  - Entering down from up keeps dir as is until the first down step, then dir=0.
  - Entering up sets dir=1 on the next step.
- Arithmetic is modulo 2**WIDTH. No wrap other than those above can occur, because period_act changes only at update events.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight pulse is dropped.

Decomposition:
- Package pwm_pkg:
  - Mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_UPDOWN=2'b10.
  - Default WIDTH/PRESC_W localparams.
- Sub-module pwm_prescaler:
  - Inputs: clk, rst_n, en, clr, prescale.
  - Output: step.
  - Holds psc_cnt and the >= compare. Instantiated once inside pwm_timebase.

Test Plan:
- Reset/clear: rst_n low then high, en=1, prescale=0, 3 clks, count_reset pulse 1 clk -> count_val=0. Then en=0 for 5 clks -> stays 0, no pulses.
- Up with prescale: period=8, mode=00, prescale=0, 4 clks -> count_val=4. Then prescale=1, 4 clks -> 6. Then prescale=2, 8 clks -> 8. Then 4 more clks -> 0 with one ovf and one upd pulse.
- Down wrap: from count 0, mode=01, prescale=2, 4 clks -> count_val=8, unf=1. 4 more clks -> 7. Run to 0, 4 more clks -> 8.
- Center-aligned: period=4, mode=10, prescale=0, from reset -> sequence 1,2,3,4,3,2,1,0,1 with ovf at the 4→3 step and unf at the 0→1 step.
- Shadow period: up mode, period=8, change period to 3 at count 5 -> count continues to 8, wraps to 0 with upd. Next wrap occurs after 3 (0..3), no earlier.
- Edge cases:
  - period=0 in up mode -> count_val stays 0, ovf every tick.
  - prescale reduced from 3 to 0 while psc_cnt=5 -> step on the next clk.
  - rst_n asserted mid-count -> count_val=0 and period_act=PERIOD_RST without waiting for a clk edge.
